// File: rtl/skin_centroid.sv
// skin_centroid: accumulates the coordinates of every skin pixel (mask != 0) in a
// frame and, at the vsync falling edge, divides the sums by the pixel count to get
// the centroid. The result feeds the crosshair overlay and holds for a whole frame.
// Optional build macro: CENTROID_SMOOTH_EN (average consecutive found centroids).
module skin_centroid #(
  parameter int IMG_W      = 720,
  parameter int IMG_H      = 576,
  parameter int ACC_W      = 32,
  parameter int CNT_W      = 20,
  parameter int MIN_PIXELS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [7:0]  mask,
  output logic [11:0] x_out,
  output logic [11:0] y_out,
  output logic        found_out,
  output logic        valid_out,
  output logic        busy_out
);

  localparam int HW   = $clog2(IMG_W);
  localparam int VW   = $clog2(IMG_H);
  localparam int IT_W = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  logic [HW-1:0]    h_cnt_q;
  logic [VW-1:0]    v_cnt_q;
  logic             vsync_q;
  logic [ACC_W-1:0] sum_x_q, sum_y_q;
  logic [CNT_W-1:0] cnt_q;
  state_t           state_q;
  logic [IT_W-1:0]  iter_q;
  logic [ACC_W-1:0] quo_x_q, quo_y_q;
  logic [ACC_W-1:0] rem_x_q, rem_y_q;
  logic [ACC_W-1:0] dvsr_q;
  logic             ok_q;
  logic [ACC_W:0]   step_x_d, step_y_d;
  logic             frame_end, skin, cnt_ok;
  logic             unused_hsync;

  // One restoring-division step: shift in the next dividend bit and subtract the
  // divisor when it fits. Returns {new remainder, quotient bit}.
  function automatic logic [ACC_W:0] div_step(input logic [ACC_W-1:0] rem,
                                               input logic             dvd_bit,
                                               input logic [ACC_W-1:0] dvsr);
    logic [ACC_W:0] sh;
    sh = {rem, dvd_bit};
    if (sh >= {1'b0, dvsr}) div_step = {ACC_W'(sh - {1'b0, dvsr}), 1'b1};
    else                    div_step = {ACC_W'(sh), 1'b0};
  endfunction

`ifdef CENTROID_SMOOTH_EN
  // Rounded mean of the previous and the new coordinate; 13-bit sum cannot overflow.
  function automatic logic [11:0] smooth(input logic [11:0] prev, input logic [11:0] cur);
    logic [12:0] s;
    s = {1'b0, prev} + {1'b0, cur} + 13'd1;
    smooth = 12'(s >> 1);
  endfunction
`endif

  assign frame_end    = vsync_q & ~vsync_in;
  assign skin         = vsync_in & de_in & (|mask);
  assign cnt_ok       = (cnt_q >= CNT_W'(MIN_PIXELS));
  assign step_x_d     = div_step(rem_x_q, quo_x_q[ACC_W-1], dvsr_q);
  assign step_y_d     = div_step(rem_y_q, quo_y_q[ACC_W-1], dvsr_q);
  assign unused_hsync = hsync_in;

  // Raster position of the next active pixel; held at the origin during vertical blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else if (!vsync_in) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else if (de_in) begin
      if (h_cnt_q == HW'(IMG_W - 1)) begin
        h_cnt_q <= '0;
        v_cnt_q <= (v_cnt_q == VW'(IMG_H - 1)) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_q <= h_cnt_q + 1'b1;
      end
    end
  end

  // Per-frame coordinate sums and skin count; restart from zero at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      sum_x_q <= '0;
      sum_y_q <= '0;
      cnt_q   <= '0;
    end else begin
      vsync_q <= vsync_in;
      if (frame_end) begin
        sum_x_q <= '0;
        sum_y_q <= '0;
        cnt_q   <= '0;
      end else if (skin) begin
        sum_x_q <= sum_x_q + ACC_W'(h_cnt_q);
        sum_y_q <= sum_y_q + ACC_W'(v_cnt_q);
        cnt_q   <= cnt_q + 1'b1;
      end
    end
  end

  // Divider datapath: load the frame snapshot, then one quotient bit per clock.
  always_ff @(posedge clk) begin
    if (frame_end) begin
      quo_x_q <= sum_x_q;
      quo_y_q <= sum_y_q;
      rem_x_q <= '0;
      rem_y_q <= '0;
      dvsr_q  <= cnt_ok ? ACC_W'(cnt_q) : ACC_W'(1);
      ok_q    <= cnt_ok;
    end else if (state_q == DIV) begin
      quo_x_q <= {quo_x_q[ACC_W-2:0], step_x_d[0]};
      quo_y_q <= {quo_y_q[ACC_W-2:0], step_y_d[0]};
      rem_x_q <= step_x_d[ACC_W:1];
      rem_y_q <= step_y_d[ACC_W:1];
    end
  end

  // Control FSM: a frame end (re)starts the division; DONE publishes the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      iter_q    <= '0;
      x_out     <= 12'hFFF;
      y_out     <= 12'hFFF;
      found_out <= 1'b0;
      valid_out <= 1'b0;
      busy_out  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (frame_end) begin
        state_q  <= DIV;
        iter_q   <= '0;
        busy_out <= 1'b1;
      end else begin
        case (state_q)
          DIV: begin
            iter_q <= iter_q + 1'b1;
            if (iter_q == IT_W'(ACC_W - 1)) state_q <= DONE;
          end
          DONE: begin
            state_q   <= IDLE;
            busy_out  <= 1'b0;
            valid_out <= 1'b1;
            found_out <= ok_q;
            if (!ok_q) begin
              x_out <= 12'hFFF;
              y_out <= 12'hFFF;
`ifdef CENTROID_SMOOTH_EN
            end else if (found_out) begin
              x_out <= smooth(x_out, quo_x_q[11:0]);
              y_out <= smooth(y_out, quo_y_q[11:0]);
`endif
            end else begin
              x_out <= quo_x_q[11:0];
              y_out <= quo_y_q[11:0];
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
